// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store unit: op codes, FSM states,
// byte-enable width and small op-decoding helpers.
package mem_access_pkg;

  localparam int DM_BE_W = 4;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LBU  = 4'd2;
  localparam logic [3:0] MEM_LH   = 4'd3;
  localparam logic [3:0] MEM_LHU  = 4'd4;
  localparam logic [3:0] MEM_LW   = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  // Codes 9..15 fall outside the valid range and behave like MEM_NONE.
  function automatic logic op_valid(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_SW);
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic size_e op_size(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
      default:                 return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lane);
    case (op_size(op))
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Load-data lane select and sign/zero extension; shared with the writeback path.
module mem_extend
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic signed [7:0]  b_sel;
  logic signed [15:0] h_sel;

  always_comb begin
    b_sel  = word[{lane, 3'b000} +: 8];
    h_sel  = lane[1] ? word[31:16] : word[15:0];
    result = '0;
    case (op)
      MEM_LB:  result = 32'(b_sel);
      MEM_LBU: result = {24'b0, b_sel};
      MEM_LH:  result = 32'(h_sel);
      MEM_LHU: result = {16'b0, h_sel};
      MEM_LW:  result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: one byte/halfword/word transfer per request over
// a req/ack bus, with alignment check and bus timeout.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [3:0]         mem_op,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               busy,
  output logic               done,
  output logic [31:0]        rdata,
  output logic               err_align,
  output logic               err_timeout,
  output logic               dm_req,
  output logic               dm_we,
  output logic [DM_BE_W-1:0] dm_be,
  output logic [31:0]        dm_addr,
  output logic [31:0]        dm_wdata,
  input  logic               dm_ack,
  input  logic [31:0]        dm_rdata
);

  localparam int CNT_W = $clog2(DM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DM_TIMEOUT - 1);

  logic [1:0]         state;
  logic [3:0]         op_q;
  logic [1:0]         lane_q;
  logic [CNT_W-1:0]   cnt;
  logic [DM_BE_W-1:0] be_fmt;
  logic [31:0]        wd_fmt;
  logic [31:0]        ld_data;

  // Bus-side formatting is computed from the request inputs and registered
  // on acceptance, so the dm_* outputs never follow start combinationally.
  always_comb begin
    be_fmt = 4'b1111;
    wd_fmt = wdata;
    case (op_size(mem_op))
      SZ_BYTE: begin
        be_fmt = 4'b0001 << addr[1:0];
        wd_fmt = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be_fmt = 4'b0011 << addr[1:0];
        wd_fmt = {2{wdata[15:0]}};
      end
      default: begin
        be_fmt = 4'b1111;
        wd_fmt = wdata;
      end
    endcase
  end

  mem_extend u_ext (
    .op    (op_q),
    .lane  (lane_q),
    .word  (dm_rdata),
    .result(ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      op_q        <= MEM_NONE;
      lane_q      <= 2'b00;
      cnt         <= '0;
      rdata       <= '0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      dm_we       <= 1'b0;
      dm_be       <= '0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && op_valid(mem_op)) begin
            op_q        <= mem_op;
            lane_q      <= addr[1:0];
            cnt         <= '0;
            err_timeout <= 1'b0;
            if (misaligned(mem_op, addr[1:0])) begin
              state     <= ST_RESP;
              err_align <= 1'b1;
              rdata     <= '0;
            end else begin
              state     <= ST_BUS;
              err_align <= 1'b0;
              dm_addr   <= {addr[31:2], 2'b00};
              dm_be     <= be_fmt;
              dm_we     <= op_store(mem_op);
              dm_wdata  <= wd_fmt;
            end
          end
        end
        ST_BUS: begin
          if (dm_ack) begin
            state <= ST_RESP;
            rdata <= ld_data;
            dm_be <= '0;
            dm_we <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_RESP;
            err_timeout <= 1'b1;
            rdata       <= '0;
            dm_be       <= '0;
            dm_we       <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_RESP);
  assign dm_req = (state == ST_BUS);

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: table-driven transfers plus hand-written
// sequences for ignored starts, timeout and reset in the middle of a transfer.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, start, dm_ack;
  logic [3:0]  mem_op;
  logic [31:0] addr, wdata, dm_rdata;
  logic        busy, done, err_align, err_timeout, dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] rdata, dm_addr, dm_wdata;

  int checks = 0;
  int errors = 0;

  mem_access #(.DM_TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .err_align(err_align), .err_timeout(err_timeout), .dm_req(dm_req),
    .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          wait_n;
    logic        req;
    logic [3:0]  be;
    logic        we;
    logic [31:0] ew;
    logic [31:0] rdat;
    int          lat;
    logic        al;
  } vec_t;

  vec_t tbl[12];

  int          r_lat;
  logic [31:0] r_rdata;
  logic        r_al, r_to, r_req;
  logic [3:0]  r_be_f, r_be_l;
  logic        r_we_f, r_we_l;
  logic [31:0] r_addr_f, r_addr_l, r_wd_f, r_wd_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request and plays the memory: ack arrives in BUS cycle wait_n+1.
  // With spam set, start is held high during BUS to show it is ignored.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int wait_n, input bit spam);
    int bus_n;
    @(negedge clk);
    start = 1'b1; mem_op = op; addr = a; wdata = wd;
    r_lat = -1; r_req = 1'b0; bus_n = 0;
    r_rdata = 'x; r_al = 1'bx; r_to = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (dm_req) begin
        bus_n++;
        r_req = 1'b1;
        if (bus_n == 1) begin
          r_be_f = dm_be; r_we_f = dm_we; r_addr_f = dm_addr; r_wd_f = dm_wdata;
        end
        r_be_l = dm_be; r_we_l = dm_we; r_addr_l = dm_addr; r_wd_l = dm_wdata;
      end
      if (done) begin
        r_lat = k; r_rdata = rdata; r_al = err_align; r_to = err_timeout;
        break;
      end
      dm_ack   = dm_req && (bus_n == wait_n + 1);
      dm_rdata = rd;
      start    = spam && dm_req;
      mem_op   = spam ? MEM_SW : op;
    end
    dm_ack = 1'b0;
    start  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    rstn = 1'b0; start = 1'b0; dm_ack = 1'b0;
    mem_op = MEM_NONE; addr = '0; wdata = '0; dm_rdata = '0;

    tbl[0]  = '{MEM_SW,  32'h10,  32'hDEADBEEF, 32'h0,        0, 1, 4'b1111, 1, 32'hDEADBEEF, 32'h0,        2, 0};
    tbl[1]  = '{MEM_LB,  32'h13,  32'h0,        32'h80000000, 0, 1, 4'b1000, 0, 32'h0,        32'hFFFFFF80, 2, 0};
    tbl[2]  = '{MEM_LBU, 32'h13,  32'h0,        32'h80000000, 0, 1, 4'b1000, 0, 32'h0,        32'h00000080, 2, 0};
    tbl[3]  = '{MEM_LH,  32'h22,  32'h0,        32'h80011234, 0, 1, 4'b1100, 0, 32'h0,        32'hFFFF8001, 2, 0};
    tbl[4]  = '{MEM_LHU, 32'h22,  32'h0,        32'h80011234, 0, 1, 4'b1100, 0, 32'h0,        32'h00008001, 2, 0};
    tbl[5]  = '{MEM_LW,  32'h6,   32'h0,        32'h0,        0, 0, 4'b0000, 0, 32'h0,        32'h0,        1, 1};
    tbl[6]  = '{MEM_SH,  32'h5,   32'h1234,     32'h0,        0, 0, 4'b0000, 0, 32'h0,        32'h0,        1, 1};
    tbl[7]  = '{MEM_LW,  32'h104, 32'h0,        32'h12345678, 2, 1, 4'b1111, 0, 32'h0,        32'h12345678, 4, 0};
    tbl[8]  = '{MEM_SH,  32'h2,   32'h0000BEEF, 32'h0,        0, 1, 4'b1100, 1, 32'hBEEFBEEF, 32'h0,        2, 0};
    tbl[9]  = '{MEM_SB,  32'h3,   32'h00000011, 32'h0,        1, 1, 4'b1000, 1, 32'h11111111, 32'h0,        3, 0};
    tbl[10] = '{MEM_LB,  32'h1,   32'h0,        32'h00007F00, 0, 1, 4'b0010, 0, 32'h0,        32'h0000007F, 2, 0};
    tbl[11] = '{MEM_LH,  32'h0,   32'h0,        32'h1234FFFE, 0, 1, 4'b0011, 0, 32'h0,        32'hFFFFFFFE, 2, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_errs", {30'b0, err_align, err_timeout}, 32'h0);
    chk("rst_req_we", {30'b0, dm_req, dm_we}, 32'h0);
    chk("rst_be", 32'(dm_be), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    rstn = 1'b1;

    // NONE and out-of-range ops are ignored; stray ack in IDLE is ignored
    @(negedge clk);
    start = 1'b1; mem_op = MEM_NONE; dm_ack = 1'b1;
    @(negedge clk);
    chk("none_busy", 32'(busy), 32'h0);
    chk("none_req", 32'(dm_req), 32'h0);
    mem_op = 4'd12;
    @(negedge clk);
    chk("op12_busy", 32'(busy), 32'h0);
    chk("op12_done", 32'(done), 32'h0);
    start = 1'b0; dm_ack = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].wait_n, 1'b0);
      chk($sformatf("v%0d_latency", i), 32'(r_lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d_rdata", i), r_rdata, tbl[i].rdat);
      chk($sformatf("v%0d_err_align", i), 32'(r_al), 32'(tbl[i].al));
      chk($sformatf("v%0d_err_timeout", i), 32'(r_to), 32'h0);
      chk($sformatf("v%0d_req_seen", i), 32'(r_req), 32'(tbl[i].req));
      if (tbl[i].req) begin
        chk($sformatf("v%0d_be", i), 32'(r_be_f), 32'(tbl[i].be));
        chk($sformatf("v%0d_we", i), 32'(r_we_f), 32'(tbl[i].we));
        chk($sformatf("v%0d_addr", i), r_addr_f, tbl[i].a & 32'hFFFFFFFC);
        chk($sformatf("v%0d_be_last", i), 32'(r_be_l), 32'(tbl[i].be));
        chk($sformatf("v%0d_addr_last", i), r_addr_l, tbl[i].a & 32'hFFFFFFFC);
        if (tbl[i].we) begin
          chk($sformatf("v%0d_wdata", i), r_wd_f, tbl[i].ew);
          chk($sformatf("v%0d_wdata_last", i), r_wd_l, tbl[i].ew);
        end
      end
    end

    // Timeout with no ack and start pulses while busy
    run_txn(MEM_LW, 32'h40, 32'h0, 32'hCAFEF00D, 100, 1'b1);
    chk("to_latency", 32'(r_lat), 32'd5);
    chk("to_err_timeout", 32'(r_to), 32'h1);
    chk("to_err_align", 32'(r_al), 32'h0);
    chk("to_rdata", r_rdata, 32'h0);
    @(negedge clk);
    chk("to_busy_after", 32'(busy), 32'h0);
    @(negedge clk);
    chk("to_no_restart", {30'b0, busy, done}, 32'h0);

    // Reset in the middle of a delayed transfer
    @(negedge clk);
    start = 1'b1; mem_op = MEM_LW; addr = 32'h200;
    @(negedge clk);
    start = 1'b0;
    chk("mid_req_on", 32'(dm_req), 32'h1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_req_off", 32'(dm_req), 32'h0);
    chk("mid_no_done", 32'(done), 32'h0);
    rstn = 1'b1;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("mid_no_late_done", 32'(seen_done), 32'h0);
    chk("mid_idle", 32'(busy), 32'h0);

    run_txn(MEM_SB, 32'h1, 32'h000000AB, 32'h0, 0, 1'b0);
    chk("post_sb_be", 32'(r_be_f), 32'h2);
    chk("post_sb_wdata", r_wd_f, 32'hABABABAB);
    chk("post_sb_we", 32'(r_we_f), 32'h1);
    chk("post_sb_latency", 32'(r_lat), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
